// File: rtl/ring_hub.sv
// Ring-side line-fill hub: round-robin arbitration over supercore ports,
// one backend line read per transaction, full line returned with a ready pulse.
module ring_hub #(
  parameter int unsigned NUM_SC     = 4,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SC-1:0]        sc_req,
  input  logic [NUM_SC*ADDR_W-1:0] sc_addr,
  output logic [NUM_SC-1:0]        sc_ready,
  output logic [LINE_WORDS*64-1:0] sc_rdata,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [63:0]              mem_rdata,
  output logic                     busy,
  output logic [31:0]              lines_served
);

  localparam int unsigned IDX_W = (NUM_SC > 1) ? $clog2(NUM_SC) : 1;
  localparam int unsigned CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DELIVER} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, grant;
  logic [IDX_W-1:0]    pick, cand;
  logic                found;
  logic [CNT_W-1:0]    beat_cnt;
  logic [NUM_SC-1:0]   rearm, elig;
  logic [ADDR_W-1:0]   line_addr, sel_addr;

  assign elig     = sc_req & rearm;
  assign sel_addr = sc_addr[pick*ADDR_W +: ADDR_W];

  // First eligible port at or after rr_ptr, wrapping upward.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_SC; off++) begin
      cand = IDX_W'((32'(rr_ptr) + off) % NUM_SC);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ADDR;
      ADDR:    if (mem_gnt) state_nxt = DATA;
      DATA:    if (mem_rvalid && beat_cnt == LAST_BEAT) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sc_ready = '0;
    mem_req  = (state == ADDR);
    mem_addr = (state == ADDR) ? line_addr : '0;
    busy     = (state != IDLE);
    if (state == DELIVER) sc_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      grant        <= '0;
      beat_cnt     <= '0;
      rearm        <= '1;
      line_addr    <= '0;
      sc_rdata     <= '0;
      lines_served <= '0;
    end else begin
      // Dropping req re-arms a port, even in the cycle it is being served.
      rearm <= ~sc_req | (rearm & ~sc_ready);
      case (state)
        IDLE: if (found) begin
          grant     <= pick;
          line_addr <= sel_addr & ~ADDR_W'(63);
          rr_ptr    <= IDX_W'((32'(pick) + 32'd1) % NUM_SC);
        end
        ADDR: if (mem_gnt) beat_cnt <= '0;
        DATA: if (mem_rvalid) begin
          sc_rdata[beat_cnt*64 +: 64] <= mem_rdata;
          beat_cnt                    <= beat_cnt + CNT_W'(1);
        end
        DELIVER: lines_served <= lines_served + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_hub.sv
// Directed bench for ring_hub: arbitration order, rearm rule, backend stalls,
// mid-transaction reset and stray beats, with hand-computed expectations.
module tb_ring_hub;

  localparam int NUM_SC = 4;
  localparam int LW     = 8;
  localparam int AW     = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_SC-1:0]    sc_req;
  logic [NUM_SC*AW-1:0] sc_addr;
  logic [NUM_SC-1:0]    sc_ready;
  logic [LW*64-1:0]     sc_rdata;
  logic                 mem_req;
  logic [AW-1:0]        mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [63:0]          mem_rdata;
  logic                 busy;
  logic [31:0]          lines_served;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  ring_hub #(.NUM_SC(NUM_SC), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .sc_req(sc_req), .sc_addr(sc_addr), .sc_ready(sc_ready), .sc_rdata(sc_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .lines_served(lines_served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] word(input int w);
    return sc_rdata[w*64 +: 64];
  endfunction

  task automatic do_reset;
    sc_req     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rst        = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    tick();
  endtask

  // Backend model: wait for mem_req, grant after gdly cycles, return words seed+w.
  task automatic do_fill(input logic [63:0] seed, input int gdly, input bit gappy,
                         output logic [NUM_SC-1:0] rdy, output logic [AW-1:0] addr,
                         output int req_at, output int rdy_at);
    int t0;
    int n;
    int w;
    bit ph;
    t0 = cyc;
    n  = 0;
    w  = 0;
    ph = 1'b0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!mem_req) begin
      check("mem_req_timeout", 64'd0, 64'd1);
      rdy = '0; addr = '0; req_at = -1; rdy_at = -1;
      return;
    end
    req_at = cyc - t0;
    addr   = mem_addr;
    for (int d = 0; d < gdly; d++) begin
      check("mem_req_hold", 64'(mem_req), 64'd1);
      check("mem_addr_hold", mem_addr, addr);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("mem_req_drop", 64'(mem_req), 64'd0);
    for (int k = 0; k < 40 && w < LW; k++) begin
      if (gappy && ph) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 64'hBAD0_BAD0;
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata  = seed + 64'(w);
        w++;
      end
      ph = !ph;
      tick();
    end
    mem_rvalid = 1'b0;
    rdy    = sc_ready;
    rdy_at = cyc - t0;
    tick();
  endtask

  initial begin
    logic [NUM_SC-1:0] rdy;
    logic [AW-1:0]     addr;
    int                req_at, rdy_at, seen;

    sc_addr = '0;
    rst     = 1'b0;
    do_reset();
    rst = 1'b0;
    #2;
    check("rst_ready", 64'(sc_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_lines", 64'(lines_served), 64'd0);
    check("rst_rdata", word(0), 64'd0);
    #2 rst = 1'b1;
    tick();

    // 1: single port, zero-wait backend
    sc_addr[0*AW +: AW] = 64'h1234;
    sc_req = 4'b0001;
    do_fill(64'hA0, 0, 1'b0, rdy, addr, req_at, rdy_at);
    check("t1_req_cycle", 64'(req_at), 64'd1);
    check("t1_mem_addr", addr, 64'h1200);
    check("t1_ready", 64'(rdy), 64'h1);
    check("t1_ready_cycle", 64'(rdy_at), 64'd10);
    check("t1_word0", word(0), 64'hA0);
    check("t1_word7", word(7), 64'hA7);
    check("t1_lines", 64'(lines_served), 64'd1);
    sc_req = '0;
    tick();

    // 2: all ports at once, RR order from a fresh pointer
    do_reset();
    for (int i = 0; i < NUM_SC; i++) sc_addr[i*AW +: AW] = 64'h1000 * 64'(i + 1) + 64'h3F;
    sc_req = 4'hF;
    for (int i = 0; i < NUM_SC; i++) begin
      do_fill(64'h100 * 64'(i + 1), 0, 1'b0, rdy, addr, req_at, rdy_at);
      check($sformatf("t2_ready_%0d", i), 64'(rdy), 64'(1 << i));
      check($sformatf("t2_addr_%0d", i), addr, 64'h1000 * 64'(i + 1));
      check($sformatf("t2_word3_%0d", i), word(3), 64'h100 * 64'(i + 1) + 64'd3);
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy) seen++;
      tick();
    end
    check("t2_no_regrant", 64'(seen), 64'd0);
    check("t2_lines", 64'(lines_served), 64'd4);
    sc_req = '0;
    tick();

    // 3: port 2 holds req after service, then drops for one cycle
    sc_addr[2*AW +: AW] = 64'h2007F;
    sc_req = 4'b0100;
    do_fill(64'h300, 0, 1'b0, rdy, addr, req_at, rdy_at);
    check("t3_ready_a", 64'(rdy), 64'h4);
    check("t3_addr", addr, 64'h20040);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req || busy) seen++;
      tick();
    end
    check("t3_held_no_grant", 64'(seen), 64'd0);
    sc_req = '0;
    tick();
    sc_req = 4'b0100;
    do_fill(64'h400, 0, 1'b0, rdy, addr, req_at, rdy_at);
    check("t3_ready_b", 64'(rdy), 64'h4);
    check("t3_word0_b", word(0), 64'h400);
    check("t3_lines", 64'(lines_served), 64'd6);
    sc_req = '0;
    tick();

    // 4: delayed grant and gappy beats
    sc_addr[1*AW +: AW] = 64'hABCD_EF17;
    sc_req = 4'b0010;
    do_fill(64'h500, 5, 1'b1, rdy, addr, req_at, rdy_at);
    check("t4_addr", addr, 64'hABCD_EF00);
    check("t4_ready", 64'(rdy), 64'h2);
    for (int w = 0; w < LW; w++) check($sformatf("t4_word%0d", w), word(w), 64'h500 + 64'(w));
    check("t4_single_pulse", 64'(sc_ready), 64'd0);
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_lines", 64'(lines_served), 64'd7);
    sc_req = '0;
    tick();

    // 5: reset after 3 beats
    sc_addr[3*AW +: AW] = 64'h4444;
    sc_req = 4'b1000;
    seen = 0;
    while (!mem_req && seen < 20) begin
      tick();
      seen++;
    end
    check("t5_mem_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int w = 0; w < 3; w++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h600 + 64'(w);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_mem_req_clr", 64'(mem_req), 64'd0);
    check("t5_rdata_clr", word(0), 64'd0);
    check("t5_lines_clr", 64'(lines_served), 64'd0);
    sc_req = '0;
    #2 rst = 1'b1;
    seen = 0;
    for (int w = 3; w < LW; w++) begin
      mem_rdata = 64'h600 + 64'(w);
      tick();
      if (sc_ready != '0 || busy) seen++;
    end
    mem_rvalid = 1'b0;
    check("t5_no_ready", 64'(seen), 64'd0);
    check("t5_beats_ignored", word(0), 64'd0);
    sc_addr[0*AW +: AW] = 64'h8888;
    sc_req = 4'b0001;
    do_fill(64'h700, 0, 1'b0, rdy, addr, req_at, rdy_at);
    check("t5_ready_after", 64'(rdy), 64'h1);
    check("t5_addr_after", addr, 64'h8880);
    check("t5_word7_after", word(7), 64'h707);
    check("t5_lines_after", 64'(lines_served), 64'd1);
    sc_req = '0;
    tick();

    // 6: stray beats while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD;
    tick();
    tick();
    mem_rvalid = 1'b0;
    check("t6_word0", word(0), 64'h700);
    check("t6_word1", word(1), 64'h701);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_mem_req", 64'(mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ring_hub.md
Name: ring_hub

Overview:
Ring-side arbiter and line-fill engine sitting directly below the supercores.
- Accepts line-fill requests from NUM_SC supercore ring ports and picks one per transaction with a round-robin arbiter.
- Issues a single line read to the memory backend, collects LINE_WORDS 64-bit beats into a line buffer, then returns the full line to the winning supercore with a one-cycle ready pulse.

Parameters:
- NUM_SC, 4, number of supercore ring ports.
- LINE_WORDS, 8, 64-bit words per cache line (line = 64 bytes).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- sc_req  in  NUM_SC  per-port line request, level, held by supercore.
- sc_addr  in  NUM_SC*ADDR_W  per-port request address; port i at bits [i*ADDR_W +: ADDR_W].
- sc_ready  out  NUM_SC  one-cycle pulse to the served port, line valid on sc_rdata.
- sc_rdata  out  LINE_WORDS*64  line buffer, broadcast to all ports; word w at [w*64 +: 64].
- mem_req  out  1  backend read request.
- mem_addr  out  ADDR_W  line-aligned read address.
- mem_gnt  in  1  backend accepts request (mem_req & mem_gnt = handshake).
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  64  read beat data.
- busy  out  1  high in any state other than IDLE.
- lines_served  out  32  count of delivered lines, wraps at 2^32.

Behaviour:
Reset (rst low, asynchronous):
- All outputs 0, sc_rdata cleared, state IDLE.
- RR pointer 0, beat counter 0, all rearm flags set.
- Reset mid-transaction abandons it; beats arriving after reset release are ignored.

Eligibility:
- Port i is eligible when sc_req[i]=1 and rearm[i]=1.
- rearm[i] clears when port i receives sc_ready.
- rearm[i] sets again on any cycle sc_req[i]=0.
- A port holding req high across its own fill is therefore never served twice.

FSM states: IDLE, ADDR, DATA, DELIVER.

IDLE:
- If any port is eligible, grant the first eligible port at or after the RR pointer, searching upward with wrap.
- Latch grant index and line address = sc_addr with low 6 bits zeroed.
- RR pointer <= grant+1 mod NUM_SC.
- Go to ADDR.

ADDR:
- mem_req=1, mem_addr=latched line address.
- Hold both stable until mem_gnt=1.
- On the handshake cycle: mem_req drops next cycle, beat counter <= 0, go to DATA.

DATA:
- Each cycle with mem_rvalid=1, write mem_rdata into buffer word[beat counter] and increment the counter.
- When the beat with counter = LINE_WORDS-1 is written, go to DELIVER.
- Gaps in mem_rvalid are allowed, with no timeout.

DELIVER:
- sc_ready[grant]=1 for exactly one cycle, lines_served++, return to IDLE.

Stray beats:
- mem_rvalid in IDLE, ADDR or DELIVER is dropped and does not touch the buffer.

sc_rdata stability:
- sc_rdata is updated only in DATA.
- It holds the last delivered line until the next transaction's first beat.

Latency with zero-wait backend (mem_gnt same cycle, rvalid every cycle from the cycle after gnt):
- req sampled at cycle 0, mem_req at cycle 1, beats at cycles 2-9, sc_ready at cycle 10.

Concurrency and address handling:
- Requests arriving while busy wait; sc_req/sc_addr changes during a transaction have no effect on it.
- At most one sc_ready bit is set in any cycle.

Test Plan:
1. Single port 0 requests addr 0x1234 with zero-wait backend returning words 0xA0..0xA7 -> mem_addr=0x1200 at cycle 1, sc_ready[0] pulses at cycle 10, sc_rdata word0=0xA0 and word7=0xA7, lines_served=1.
2. Ports 0-3 all request at once and hold -> service order 0,1,2,3; each port served once until it drops req; lines_served=4.
3. Port 2 keeps sc_req high for 20 cycles after its sc_ready -> no second grant to port 2; after it drops req for one cycle and re-raises, it is served again.
4. mem_gnt delayed 5 cycles and mem_rvalid toggling 1,0,1,0 -> mem_req/mem_addr stable until gnt; exactly 8 beats captured in order; single sc_ready pulse.
5. rst pulsed low after 3 of 8 beats -> immediate clear of outputs and buffer; remaining beats ignored; no sc_ready; next request completes normally.
6. mem_rvalid=1 with data 0xDEAD while IDLE -> sc_rdata unchanged, no state change.
